// File: rtl/pll_reset_sequencer_if.sv
// Purpose : bundles the PLL supervision signals between the sequencer and its PLL/system side.
// Latency : none, wiring only.
// Backpressure: none; level signals plus the single-cycle clear_fault pulse.
// Ports (master = sequencer view):
//   i_pll_locked     PLL lock indicator, asynchronous to the reference clock
//   i_clear_fault    single-cycle pulse that leaves FAULT
//   o_pll_rst        reset to the PLL
//   o_sys_rst        active-high reset for logic clocked by the PLL outputs
//   o_ready          high only while running
//   o_fault          high only in FAULT
//   o_retry_count    lock timeouts in the current acquisition sequence
//   o_lock_loss_count lock losses seen while running, saturating
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 4,
    parameter int LOSS_CNT_W  = 8
);
    // A zero-retry build still needs a 1-bit counter port.
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic                  i_pll_locked;
    logic                  i_clear_fault;
    logic                  o_pll_rst;
    logic                  o_sys_rst;
    logic                  o_ready;
    logic                  o_fault;
    logic [RW-1:0]         o_retry_count;
    logic [LOSS_CNT_W-1:0] o_lock_loss_count;

    modport master (
        input  i_pll_locked, i_clear_fault,
        output o_pll_rst, o_sys_rst, o_ready, o_fault, o_retry_count, o_lock_loss_count
    );

    modport slave (
        output i_pll_locked, i_clear_fault,
        input  o_pll_rst, o_sys_rst, o_ready, o_fault, o_retry_count, o_lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Purpose : pulses the PLL reset, waits for a stable lock, then releases the system reset;
//           retries on lock timeout and parks in FAULT once retries are exhausted.
// Latency : lock sampled at edge N -> STABLE after N+2, ready after N+2+STABLE_CYCLES.
// Backpressure: none; outputs are registered levels decoded from the next state.
// Ports:
//   i_refclk  free-running reference clock, the only clock of this block
//   i_rst     synchronous active-high reset
//   bus       pll_reset_sequencer_if master modport (lock in, clear_fault in, resets/status out)
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  i_refclk,
    input  logic                  i_rst,
    pll_reset_sequencer_if.master bus
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    // One shared cycle counter sized for the longest phase, so it never wraps.
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                      : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX = ((MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0]         RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0]         TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]         STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]         RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT  = '1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    logic                  r_sync1;
    logic                  r_locked_s;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [RW-1:0]         r_retry;
    logic [LOSS_CNT_W-1:0] r_loss;
    logic                  r_pll_rst;
    logic                  r_sys_rst;
    logic                  r_ready;
    logic                  r_fault;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [RW-1:0]         w_retry_nxt;
    logic [LOSS_CNT_W-1:0] w_loss_nxt;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= bus.i_pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_LOCK: begin
                // Lock wins over a coincident timeout.
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_PLL_RST;
                        w_retry_nxt = r_retry + RW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STABLE: begin
                // A drop restarts the lock wait without costing a retry.
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STB_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                    if (r_loss != LOSS_SAT) begin
                        w_loss_nxt = r_loss + LOSS_CNT_W'(1);
                    end
                end
            end
            S_FAULT: begin
                // Lock state is deliberately ignored here; only an explicit clear restarts.
                if (bus.i_clear_fault) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_pll_rst <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

    assign bus.o_pll_rst         = r_pll_rst;
    assign bus.o_sys_rst         = r_sys_rst;
    assign bus.o_ready           = r_ready;
    assign bus.o_fault           = r_fault;
    assign bus.o_retry_count     = r_retry;
    assign bus.o_lock_loss_count = r_loss;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the Cyclone V clock PLL from the free-running 100 MHz reference clock.
- Drives the PLL reset and consumes its asynchronous `locked` output.
- Releases a system reset only after lock has been continuously stable, retries lock acquisition on timeout, and reports a fault if retries are exhausted.
- Sits between the board reset/refclk and the PLL wrapper; its `sys_rst` gates all logic clocked by the PLL outputs.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 100000: cycles to wait for lock per attempt, i.e. 1 ms (>=1).
- STABLE_CYCLES, 1024: consecutive locked cycles required before release (>=1).
- MAX_RETRIES, 4: re-attempts after the first timeout before FAULT (>=0).
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- refclk, in, 1: 100 MHz reference clock; the single clock of this block.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL lock indicator, asynchronous to refclk.
- clear_fault, in, 1: single-cycle pulse that leaves FAULT; ignored in all other states.
- pll_rst, out, 1: reset to the PLL.
- sys_rst, out, 1: system reset for downstream logic, active high.
- ready, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- retry_count, out, RW = $clog2(MAX_RETRIES+1): timeouts in the current acquisition sequence.
- lock_loss_count, out, LOSS_CNT_W: lock losses seen in RUN; saturates at all-ones.

Behaviour:
- Sync: `pll_locked` passes through a 2-flop synchronizer (both flops reset to 0); the second flop is `locked_s`. Only `locked_s` is used internally.
- Outputs: all registered, decoded from the next state so they change on the same edge as the state.
- Reset: while `rst`=1 at an edge:
  - state=PLL_RST, cnt=0, retry_count=0, lock_loss_count=0;
  - pll_rst=1, sys_rst=1, ready=0, fault=0.
  - `rst` overrides every other input, including `clear_fault`.
- PLL_RST (pll_rst=1, sys_rst=1): cnt increments each cycle; at cnt==RST_PULSE_CYCLES-1 go to WAIT_LOCK with cnt=0. `pll_rst` is high for exactly RST_PULSE_CYCLES cycles after `rst` falls.
- WAIT_LOCK (pll_rst=0, sys_rst=1):
  - If locked_s=1, go to STABLE with cnt=0. Lock takes priority over timeout in the same cycle.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1:
    - retry_count==MAX_RETRIES: go to FAULT;
    - otherwise retry_count+1 and go to PLL_RST with cnt=0.
  - Otherwise cnt+1.
- STABLE (pll_rst=0, sys_rst=1):
  - If locked_s=0, go to WAIT_LOCK with cnt=0. The timeout restarts; retry_count is unchanged.
  - Else if cnt==STABLE_CYCLES-1, go to RUN.
  - Otherwise cnt+1.
- RUN (pll_rst=0, sys_rst=0, ready=1): if locked_s=0, then on that edge:
  - lock_loss_count+1 (saturating) and retry_count=0;
  - go to PLL_RST with cnt=0, so sys_rst=1 and ready=0 on the same edge.
- FAULT (pll_rst=1, sys_rst=1, fault=1):
  - `pll_locked` is ignored.
  - clear_fault=1: go to PLL_RST with cnt=0, retry_count=0; lock_loss_count is kept.
- Latency: if `pll_locked` is first sampled high at edge N while in WAIT_LOCK and stays high, state=STABLE after edge N+2 and ready=1 / sys_rst=0 after edge N+2+STABLE_CYCLES.
- Total attempts before FAULT = MAX_RETRIES+1.
- The counter `cnt` is wide enough for max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)-1 and never wraps.

Test Plan (all with RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_CNT_W=2):
1. Nominal lock: rst for 3 cycles then low; pll_locked rises 10 cycles later -> pll_rst high exactly 4 cycles after rst falls; ready=1 and sys_rst=0 exactly 10 edges (2+8) after pll_locked is first sampled; retry_count=0.
2. Lock glitch in STABLE: pll_locked high 5 cycles, low 1, then high -> no release during the glitch; state back to WAIT_LOCK; ready rises 10 edges after the re-rise; retry_count=0.
3. Retry then fault: pll_locked held 0 -> retry_count steps 1 then 2; fault=1 after 3*(4+50)=162 cycles following rst release; pll_rst=1, sys_rst=1 in FAULT.
4. Clear fault: from FAULT, pulse clear_fault and raise pll_locked -> fault=0 next edge, retry_count=0, pll_rst high 4 cycles, then ready=1 after sync+stable delay. A clear_fault pulse while in RUN has no effect.
5. Lock loss in RUN, repeated 4 times: drop pll_locked in RUN -> sys_rst=1 and ready=0 2 edges after the drop is sampled; lock_loss_count goes 1, 2, 3, 3 (saturates).
6. Reset mid-operation: assert rst during STABLE, and again during FAULT with clear_fault=1 -> state PLL_RST, all counters 0, fault=0, pll_rst=1, sys_rst=1 on the next edge.
